// File: rtl/ov7670_axis_frame_receiver.sv
`timescale 1ns / 1ps
// Receives RGB565 camera frames on an AXI-Stream slave, tags every pixel with its
// (x, y) position and frame markers, and buffers the words in a FWFT FIFO.
module ov7670_axis_frame_receiver #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        S_AXIS_ACLK,
  input  logic        S_AXIS_ARESET,
  input  logic [15:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  input  logic        S_AXIS_TLAST,
  output logic        S_AXIS_TREADY,
  input  logic        capture_en,
  input  logic        err_clr,
  output logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_sof,
  output logic        pix_eof,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] frame_count,
  output logic        err_short,
  output logic        err_long
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [9:0]    X_LAST = 10'(FRAME_WIDTH - 1);
  localparam logic [8:0]    Y_LAST = 9'(FRAME_HEIGHT - 1);
  localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {DISABLED, SYNC, ACTIVE} state_t;

  typedef struct packed {
    logic [15:0] data;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        sof;
    logic        eof;
  } word_t;

  state_t        state, state_next;
  logic [9:0]    x;
  logic [8:0]    y;
  logic [CW-1:0] occ;
  logic [AW-1:0] wr_ptr, rd_ptr;
  word_t         mem [FIFO_DEPTH];
  word_t         wr_word;
  logic          accept, push, pop, load, mem_nonempty;
  logic          last_pos, frame_end, frame_ok, set_short, set_long;

  // Occupancy counts the output register too, so TREADY depends only on registered state.
  assign S_AXIS_TREADY = !S_AXIS_ARESET && ((state != ACTIVE) || (occ < DEPTH));
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign push          = accept && (state == ACTIVE);
  assign pop           = pix_valid && pix_ready;
  assign mem_nonempty  = occ != CW'(pix_valid);
  assign load          = mem_nonempty && (!pix_valid || pop);

  // NOTE: every signal driven here gets a value before any branch, so no latch is inferred.
  always_comb begin
    state_next   = state;
    last_pos     = (x == X_LAST) && (y == Y_LAST);
    frame_end    = push && (S_AXIS_TLAST || last_pos);
    frame_ok     = push && S_AXIS_TLAST && last_pos;
    set_short    = push && S_AXIS_TLAST && !last_pos;
    set_long     = push && !S_AXIS_TLAST && last_pos;
    wr_word.data = S_AXIS_TDATA;
    wr_word.x    = x;
    wr_word.y    = y;
    wr_word.sof  = (x == '0) && (y == '0);
    wr_word.eof  = S_AXIS_TLAST || last_pos;
    case (state)
      DISABLED: if (capture_en) state_next = SYNC;
      SYNC:     if (accept && S_AXIS_TLAST) state_next = capture_en ? ACTIVE : DISABLED;
      ACTIVE: begin
        if (set_long)       state_next = SYNC;
        else if (frame_end) state_next = capture_en ? ACTIVE : DISABLED;
      end
      default:  state_next = DISABLED;
    endcase
  end

  // NOTE: sequential state is only ever written with non-blocking assignments.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) state <= DISABLED;
    else               state <= state_next;
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      x           <= '0;
      y           <= '0;
      frame_count <= '0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else begin
      if (frame_end) begin
        x <= '0;
        y <= '0;
      end else if (push) begin
        if (x == X_LAST) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
      if (frame_ok) frame_count <= frame_count + 1'b1;
      // A new error in the same cycle as err_clr stays set.
      if (set_short)    err_short <= 1'b1;
      else if (err_clr) err_short <= 1'b0;
      if (set_long)     err_long  <= 1'b1;
      else if (err_clr) err_long  <= 1'b0;
    end
  end

  // NOTE: the storage array is deliberately not reset; flushing pointers and occupancy empties it.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (push) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      pix_valid <= 1'b0;
      {pix_data, pix_x, pix_y, pix_sof, pix_eof} <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (load) begin
        {pix_data, pix_x, pix_y, pix_sof, pix_eof} <= mem[rd_ptr];
        pix_valid <= 1'b1;
      end else if (pop) begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_axis_frame_receiver.sv
`timescale 1ns / 1ps
// Randomized self-checking bench: a frame-level reference model predicts every FIFO word,
// TREADY, frame_count and the sticky error flags, and is compared each cycle.
module tb_ov7670_axis_frame_receiver;

  localparam int W       = 4;
  localparam int H       = 2;
  localparam int D       = 4;
  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] tdata = '0;
  logic        tvalid = 1'b0, tlast = 1'b0, tready;
  logic        capture_en = 1'b0, err_clr = 1'b0, pix_ready = 1'b1;
  logic [15:0] pix_data, frame_count;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_sof, pix_eof, pix_valid, err_short, err_long;

  ov7670_axis_frame_receiver #(
    .FRAME_WIDTH (W),
    .FRAME_HEIGHT(H),
    .FIFO_DEPTH  (D)
  ) dut (
    .S_AXIS_ACLK  (clk),
    .S_AXIS_ARESET(rst),
    .S_AXIS_TDATA (tdata),
    .S_AXIS_TVALID(tvalid),
    .S_AXIS_TLAST (tlast),
    .S_AXIS_TREADY(tready),
    .capture_en   (capture_en),
    .err_clr      (err_clr),
    .pix_data     (pix_data),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_sof      (pix_sof),
    .pix_eof      (pix_eof),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .frame_count  (frame_count),
    .err_short    (err_short),
    .err_long     (err_long)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pixel position is a linear index into the frame.
  typedef enum {M_OFF, M_SYNC, M_CAP} mode_t;
  mode_t       mode = M_OFF;
  int          pos = 0;
  logic [36:0] q[$];
  logic [15:0] m_fc = '0;
  bit          m_es = 0, m_el = 0;
  int          stall = 0, words_out = 0, acc_beats = 0;
  bit          exp_ready, is_last, ends, rst_q = 0, rand_ready = 0;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_tready", tready, 0);
      if (rst_q) begin
        check("rst_valid", pix_valid, 0);
        check("rst_pix", {pix_data, pix_x, pix_y, pix_sof, pix_eof}, 0);
        check("rst_fc", frame_count, 0);
        check("rst_err", {err_short, err_long}, 0);
      end
      mode = M_OFF; pos = 0; q.delete(); m_fc = '0; m_es = 0; m_el = 0; stall = 0;
    end else begin
      exp_ready = (mode != M_CAP) || (q.size() < D);
      check("tready", tready, exp_ready);
      check("frame_count", frame_count, m_fc);
      check("err_short", err_short, m_es);
      check("err_long", err_long, m_el);
      if (q.size() > 0 && !pix_valid) stall++;
      else stall = 0;
      if (q.size() > 0) check("latency", stall <= 1, 1);
      if (pix_valid) begin
        if (q.size() == 0) check("pix_extra", pix_valid, 0);
        else begin
          check("pix_word", {pix_data, pix_x, pix_y, pix_sof, pix_eof}, q[0]);
          if (pix_ready) begin
            void'(q.pop_front());
            words_out++;
          end
        end
      end
      if (err_clr) begin
        m_es = 0;
        m_el = 0;
      end
      case (mode)
        M_OFF:  if (capture_en) mode = M_SYNC;
        M_SYNC: if (tvalid && exp_ready && tlast) mode = capture_en ? M_CAP : M_OFF;
        M_CAP: if (tvalid && exp_ready) begin
          is_last = (pos == W * H - 1);
          ends    = tlast || is_last;
          q.push_back({tdata, 10'(pos % W), 9'(pos / W), pos == 0, ends});
          if (ends) begin
            if (tlast && is_last)  m_fc = m_fc + 16'd1;
            if (tlast && !is_last) m_es = 1;
            if (!tlast && is_last) m_el = 1;
            pos  = 0;
            mode = !tlast ? M_SYNC : (capture_en ? M_CAP : M_OFF);
          end else begin
            pos++;
          end
        end
        default: ;
      endcase
    end
    rst_q = rst;
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 pix_ready = 1'($urandom_range(1, 0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic l);
    bit ok = 0;
    int n = 0;
    tdata  = 16'($urandom);
    tlast  = l;
    tvalid = 1'b1;
    while (!ok && n < TIMEOUT) begin
      @(negedge clk);
      ok = tready;
      step();
      n++;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    if (ok) acc_beats++;
    else check("beat_timeout", ok, 1);
  endtask

  task automatic send_frame(input int n, input int last_at, input int gap_max);
    for (int i = 1; i <= n; i++) begin
      send_beat(i == last_at);
      repeat ($urandom_range(gap_max, 0)) step();
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || pix_valid) && n < TIMEOUT) begin
      step();
      n++;
    end
    check("drain", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int base, len;
    rst = 1'b1; capture_en = 1'b1; pix_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Sync frame discarded, then two captured frames
    words_out = 0;
    repeat (3) send_frame(8, 8, 0);
    wait_drain();
    check("sync_fc", frame_count, 2);
    check("sync_words", words_out, 16);

    // Backpressure: FIFO fills at 4 and nothing is lost
    pix_ready = 1'b0; acc_beats = 0;
    fork
      for (int i = 0; i < 6; i++) send_beat(1'b0);
      begin
        repeat (12) step();
        check("full_tready", tready, 0);
        check("full_accepted", acc_beats, 4);
        pix_ready = 1'b1;
      end
    join
    send_beat(1'b0);
    send_beat(1'b1);
    wait_drain();

    // Short frame, then a normal one
    send_frame(5, 5, 0);
    wait_drain();
    check("short_err", err_short, 1);
    send_frame(8, 8, 1);
    wait_drain();

    // err_clr against a simultaneous short-frame error
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("clr_alone", err_short, 0);
    for (int i = 0; i < 4; i++) send_beat(1'b0);
    err_clr = 1'b1;
    send_beat(1'b1);
    err_clr = 1'b0;
    check("clr_vs_set", err_short, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("clr_next", err_short, 0);
    wait_drain();

    // Long frame: extra beats dropped until TLAST, next frame captured
    send_frame(10, 10, 0);
    wait_drain();
    check("long_err", err_long, 1);
    send_frame(8, 8, 0);
    wait_drain();

    // Randomized traffic, lengths, backpressure, enables and clears
    rand_ready = 1;
    for (int f = 0; f < 30; f++) begin
      len = ($urandom_range(1, 0) != 0) ? 8 : int'($urandom_range(10, 3));
      capture_en = ($urandom_range(3, 0) != 0);
      if ($urandom_range(3, 0) == 0) begin
        err_clr = 1'b1; step(); err_clr = 1'b0;
      end
      send_frame(len, len, 2);
    end
    rand_ready = 0;
    step();
    pix_ready = 1'b1; capture_en = 1'b1;
    wait_drain();

    // capture_en dropped mid-frame: frame completes, then disabled
    send_frame(8, 8, 0);
    send_frame(8, 8, 0);
    wait_drain();
    base = words_out;
    send_beat(1'b0);
    send_beat(1'b0);
    capture_en = 1'b0;
    for (int i = 3; i <= 8; i++) send_beat(i == 8);
    send_frame(8, 8, 0);
    wait_drain();
    check("dis_words", words_out - base, 8);
    check("dis_tready", tready, 1);

    // Reset mid-frame: partial frame dropped, resync on next boundary
    capture_en = 1'b1;
    send_frame(8, 8, 0);
    send_frame(3, 0, 0);
    rst = 1'b1;
    repeat (2) step();
    check("rst_mid_valid", pix_valid, 0);
    rst = 1'b0;
    base = words_out;
    send_frame(8, 8, 0);
    send_frame(8, 8, 0);
    wait_drain();
    check("rst_resync_words", words_out - base, 8);
    check("rst_resync_fc", frame_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ov7670_axis_frame_receiver.md
OV7670_AXIS_FRAME_RECEIVER -- requirements
Module: ov7670_axis_frame_receiver

Interface
REQ-001 Parameter FRAME_WIDTH, default 640: pixels per line, range 2..1024.
REQ-002 Parameter FRAME_HEIGHT, default 480: lines per frame, range 2..512.
REQ-003 Parameter FIFO_DEPTH, default 16: buffer entries, power of 2, range 4..64.
REQ-004 S_AXIS_ACLK  in  1  sole clock; all logic on its rising edge.
REQ-005 S_AXIS_ARESET  in  1  reset, synchronous, active-high.
REQ-006 S_AXIS_TDATA  in  16  RGB565 pixel.
REQ-007 S_AXIS_TVALID  in  1  beat valid.
REQ-008 S_AXIS_TLAST  in  1  last pixel of frame.
REQ-009 S_AXIS_TREADY  out  1  beat accept.
REQ-010 capture_en  in  1  enable frame capture, sampled only at frame boundaries.
REQ-011 err_clr  in  1  one-cycle pulse; clears sticky error flags.
REQ-012 pix_data  out  16  buffered pixel.
REQ-013 pix_x  out  10  column of pix_data.
REQ-014 pix_y  out  9  line of pix_data.
REQ-015 pix_sof / pix_eof  out  1 each  first / last pixel of frame.
REQ-016 pix_valid  out  1  output word valid.
REQ-017 pix_ready  in  1  downstream accepts the word.
REQ-018 frame_count  out  16  count of error-free frames delivered to the FIFO, wraps at 0xFFFF.
REQ-019 err_short / err_long  out  1 each  sticky framing errors.

Function
REQ-020 Beat accepted when S_AXIS_TVALID and S_AXIS_TREADY are both 1 on a clock edge.
REQ-021 States: DISABLED, SYNC, ACTIVE.
REQ-022 DISABLED: TREADY=1; beats discarded; capture_en=1 -> SYNC.
REQ-023 SYNC: TREADY=1; beats discarded; accepted beat with TLAST=1 -> ACTIVE if capture_en=1, else DISABLED.
REQ-024 ACTIVE: TREADY=1 only when FIFO occupancy < FIFO_DEPTH (registered occupancy; no combinational path from pix_ready or TVALID to TREADY).
REQ-025 ACTIVE: each accepted beat writes {data, x, y, sof, eof} into FIFO; x,y start at 0,0.
REQ-026 x increments per accepted beat; at x=FRAME_WIDTH-1 it wraps to 0 and y increments.
REQ-027 sof=1 for the beat at x=0,y=0.
REQ-028 Normal end: beat at (FRAME_WIDTH-1, FRAME_HEIGHT-1) with TLAST=1 -> eof=1, frame_count+1, x,y cleared, stay ACTIVE if capture_en=1, else DISABLED.
REQ-029 Short frame: TLAST=1 before last position -> eof=1 on that beat, err_short=1, frame_count unchanged, x,y cleared, next state as REQ-028.
REQ-030 Long frame: last position reached with TLAST=0 -> eof=1, err_long=1, frame_count unchanged, next state SYNC (discard to next TLAST).
REQ-031 capture_en deasserted mid-frame: the current frame completes normally; DISABLED is entered only at a frame end.
REQ-032 FIFO: first-word-fall-through, registered outputs; a beat accepted at edge N yields pix_valid=1 after edge N+1 when the FIFO was empty.
REQ-033 Output word popped when pix_valid and pix_ready are both 1. pix_* fields are held stable while pix_valid=1 and pix_ready=0.
REQ-034 Simultaneous push and pop: occupancy unchanged and both operations succeed, including at full and at 1 entry.
REQ-035 Empty FIFO: pix_valid=0. Full FIFO: TREADY=0. No word is lost or duplicated.
REQ-036 err_clr clears both error flags. If an error is set in the same cycle, set wins.
REQ-037 Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-038 While reset is asserted: state=DISABLED, FIFO flushed, S_AXIS_TREADY=0, pix_valid=0, all pix_* fields=0, frame_count=0, err_short=0, err_long=0, x=y=0.
REQ-039 Reset mid-frame: partial frame discarded. After reset release with capture_en=1, capture resumes via SYNC on the next frame boundary.

Verification (FRAME_WIDTH=4, FRAME_HEIGHT=2, FIFO_DEPTH=4 unless noted)
REQ-040 Reset release, capture_en=1; 8-beat frame with TLAST on beat 8; then two 8-beat frames, pix_ready=1 -> first frame discarded; next 16 words out with (x,y) = (0,0)..(3,1), sof on words 1 and 9, eof on words 8 and 16; frame_count=2.
REQ-041 Synced, pix_ready=0, 6 beats offered -> TREADY=0 after 4 accepted beats; pix_ready=1 -> all 6 words out in order; no loss.
REQ-042 Synced, TLAST on beat 5 -> word 5 has eof=1 and (x,y)=(0,1); err_short=1; frame_count unchanged; next frame starts at (0,0).
REQ-043 Synced, 10-beat frame with TLAST on beat 10 -> word 8 eof=1; err_long=1; beats 9-10 discarded; next frame captured from (0,0).
REQ-044 err_clr pulsed in the same cycle a short frame ends -> err_short=1. err_clr pulsed on the next cycle -> err_short=0.
REQ-045 capture_en dropped at beat 3 -> frame completes (8 words, eof on 8), then DISABLED with TREADY=1 and no further words.
